// File: rtl/isp_pixel_capture.sv
// Camera bus front end: byte-pair packing, SOF/EOL tagging,
// pixel FIFO with valid/ready output, frame counters and error flags.
module isp_pixel_capture #(
  parameter int BITS       = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [7:0]       cam_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BITS-1:0]  out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic [CNT_W-1:0] pix_count,
  output logic [CNT_W-1:0] line_count,
  output logic             frame_done,
  output logic             overflow,
  output logic             odd_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = BITS + 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    FRAME
  } state_t;

  state_t          state;
  logic            vs_r, vs_d, hr_r, hr_d;
  logic [7:0]      d_r;
  logic            vs_rise, hr_rise, hr_fall;
  logic            run, clr_sticky;
  logic            phase, hold_v, sof_pend;
  logic [7:0]      hi;
  logic [BITS-1:0] hold;
  logic            push;
  logic [EW-1:0]   push_ent;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_r <= 1'b0;
      vs_d <= 1'b0;
      hr_r <= 1'b0;
      hr_d <= 1'b0;
      d_r  <= '0;
    end else begin
      vs_r <= cam_vsync;
      vs_d <= vs_r;
      hr_r <= cam_href;
      hr_d <= hr_r;
      d_r  <= cam_data;
    end
  end

  assign vs_rise    = vs_r & ~vs_d;
  assign hr_rise    = hr_r & ~hr_d;
  assign hr_fall    = ~hr_r & hr_d;
  assign run        = enable && (state == FRAME);
  assign clr_sticky = enable && (state == IDLE);

  // The held pixel leaves either when its successor completes or at line end
  always_comb begin
    push     = 1'b0;
    push_ent = '0;
    if (run && hold_v) begin
      if (hr_r && phase) begin
        push     = 1'b1;
        push_ent = {sof_pend, 1'b0, hold};
      end else if (hr_fall) begin
        push     = 1'b1;
        push_ent = {sof_pend, 1'b1, hold};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      hi         <= '0;
      hold       <= '0;
      hold_v     <= 1'b0;
      sof_pend   <= 1'b0;
      pix_count  <= '0;
      line_count <= '0;
      frame_done <= 1'b0;
      odd_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        phase    <= 1'b0;
        hold_v   <= 1'b0;
        sof_pend <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state   <= WAIT_VS;
            odd_err <= 1'b0;
          end
          WAIT_VS: begin
            if (vs_rise) begin
              state      <= FRAME;
              line_count <= '0;
              sof_pend   <= 1'b1;
              phase      <= 1'b0;
              hold_v     <= 1'b0;
            end
          end
          FRAME: begin
            if (push)
              sof_pend <= 1'b0;
            if (hr_rise)
              pix_count <= '0;
            if (hr_r) begin
              phase <= ~phase;
              if (!phase) begin
                hi <= d_r;
              end else begin
                hold   <= {hi, d_r};
                hold_v <= 1'b1;
                if (!hr_rise && pix_count != '1)
                  pix_count <= pix_count + CNT_W'(1);
              end
            end
            if (hr_fall) begin
              phase <= 1'b0;
              if (phase)
                odd_err <= 1'b1;
              if (hold_v) begin
                hold_v <= 1'b0;
                if (line_count != '1)
                  line_count <= line_count + CNT_W'(1);
              end
            end
            // Frame boundary wins over a same-cycle line end
            if (vs_rise) begin
              frame_done <= 1'b1;
              sof_pend   <= 1'b1;
              line_count <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop, wr;
  logic [EW-1:0] head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = out_valid & out_ready;
  assign wr    = push && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wptr[AW-1:0]] <= push_ent;
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop)
        rptr <= rptr + (AW+1)'(1);
      if (clr_sticky)
        overflow <= 1'b0;
      else if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign head      = mem[rptr[AW-1:0]];
  assign out_valid = !empty;
  assign out_data  = head[BITS-1:0];
  assign out_eol   = head[BITS];
  assign out_sof   = head[BITS+1];

endmodule

// File: doc/isp_pixel_capture.md
Name: isp_pixel_capture

Overview:
- Front-end stage of the ISP pipeline: captures an 8-bit parallel camera bus (vsync/href/data) and packs byte pairs into BITS-wide pixels.
- Tags each pixel with start-of-frame and end-of-line flags.
- Buffers pixels in a small FIFO and presents them on a valid/ready stream that feeds the isp_io pixel input.
- Keeps per-frame pixel and line counters and sticky error flags for readback over the logic analyzer.

Parameters:
- BITS, 16, output pixel width. Must be 16: two 8-bit bytes per pixel.
- FIFO_DEPTH, 8, pixel FIFO entries. Power of two, at least 2.
- CNT_W, 12, width of the pixel and line counters.

Ports:
- clk  input  1  system clock. Camera bus is synchronous to it; one byte per clk while href is high.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  capture enable.
- cam_vsync  input  1  frame sync. Rising edge marks frame boundary.
- cam_href  input  1  line valid.
- cam_data  input  8  camera byte.
- out_valid  output  1  pixel available.
- out_ready  input  1  downstream accepts pixel.
- out_data  output  BITS  pixel: first byte in [15:8], second byte in [7:0].
- out_sof  output  1  first pixel of frame.
- out_eol  output  1  last pixel of line.
- pix_count  output  CNT_W  pixels in current or last line.
- line_count  output  CNT_W  lines completed in current frame.
- frame_done  output  1  one-cycle pulse at frame end.
- overflow  output  1  sticky: a pixel was dropped because the FIFO was full.
- odd_err  output  1  sticky: a line ended with an unpaired byte.

Behaviour:
- Reset (async assert, sync deassert): FSM = IDLE, FIFO empty, all outputs 0.
- Input register: cam_vsync, cam_href, cam_data registered once. All edge detection uses the registered copy and its one-cycle-delayed copy.
- FSM states:
  - IDLE: enable=1 -> WAIT_VS.
  - WAIT_VS: registered vsync rising edge -> FRAME; line_count cleared; sof_pending set.
  - FRAME: capture. Next vsync rising edge -> frame_done=1 for one cycle, stays in FRAME for the next frame and re-arms sof_pending.
  - enable=0 in any state -> IDLE next cycle. Partial byte and held pixel discarded; FIFO contents kept and still drain.
- Packer, in FRAME with href high:
  - Byte phase toggles each byte: phase 0 stores the high byte; phase 1 completes a pixel.
  - The completed pixel goes into a one-entry hold register.
  - If the hold register is already occupied, its previous pixel is pushed with eol=0.
- Line end (href falling edge):
  - Held pixel pushed with eol=1; pix_count frozen; line_count increments.
  - If phase=1 (unpaired byte): the byte is dropped and odd_err set.
  - Phase reset to 0. Line with zero pixels: no push, no line_count increment.
- pix_count clears on href rising edge and increments on each completed pixel.
- out_sof = 1 on the first pushed pixel after the frame start; sof_pending then clears.
- Counters saturate at all-ones; they never wrap.
- FIFO:
  - Entry = {sof, eol, data}. Push when not full; a push while full drops the entry and sets overflow.
  - Simultaneous push and pop when full is allowed: the pop frees a slot.
  - Pop on out_valid & out_ready.
  - out_valid = FIFO not empty. Head data is registered output, stable while out_valid=1 and out_ready=0.
  - Latency: pushed entry visible at outputs the cycle after push if the FIFO was empty.
- Sticky flags clear only on reset or on the IDLE->WAIT_VS transition.
- Reset mid-frame: everything cleared immediately; capture restarts at the next vsync rising edge after enable.

Test Plan:
- Basic line: enable=1; vsync pulse; href high for 8 clks with bytes 0x01..0x08; out_ready=1 -> 4 pixels 0x0102, 0x0304, 0x0506, 0x0708. First has sof=1; last has eol=1. pix_count=4, line_count=1.
- Frame end: 3 lines of 4 pixels, then vsync rising -> frame_done high exactly 1 cycle. line_count=3 before clear. Next frame's first pixel has sof=1.
- Backpressure/overflow: FIFO_DEPTH=8, out_ready=0, 12-pixel line -> 8 entries kept (pixels 1..8 in order), overflow=1. Release out_ready -> drains 8 pixels with data stable while stalled.
- Odd byte: href high for 5 bytes 0xA0..0xA4 -> pixels 0xA0A1, 0xA2A3 (eol on 0xA2A3); 0xA4 dropped; odd_err=1.
- Simultaneous push/pop at full: FIFO full, out_ready=1 on the same cycle a new pixel completes -> no drop, overflow stays 0, FIFO stays full.
- Reset/enable mid-line: assert reset_n=0 during a line -> out_valid=0 and all counters 0 immediately. Separately, deassert enable mid-line -> held pixel discarded, queued pixels still drain, no sof until the next vsync.
